// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-way mux-sharing arbiter.
// Holds the FSM state encoding, requester count and select width.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    function automatic logic [NUM_REQ-1:0] onehot2(input logic [SEL_W-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker: the first set req bit after 'last' wins.
// Zero latency; 'any' flags that at least one request is present.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               any,
    output logic [SEL_W-1:0]   pick
);

    logic [SEL_W-1:0] w_idx;

    // Scan from furthest to nearest so the nearest set bit after 'last' is the final assignment.
    always_comb begin
        pick  = '0;
        w_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = last + SEL_W'(k);
            if (req[w_idx]) begin
                pick = w_idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mux4_share_arbiter.sv
// Round-robin owner of an external 4:1 single-bit mux with bounded hold and a break-before-make gap.
// Grant 1 cycle after req; sample 1 cycle after grant; sel moves only on the IDLE->OWN edge.
module mux4_share_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] d,
    input  logic       mux_q,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       q_out,
    output logic       q_valid,
    output logic [1:0] q_src,
    output logic       busy
);

    arb_state_t       r_state,    w_nxt_state;
    logic [3:0]       r_grant,    w_nxt_grant;
    logic [1:0]       r_sel,      w_nxt_sel;
    logic [1:0]       r_last,     w_nxt_last;
    logic [1:0]       r_q_src,    w_nxt_q_src;
    logic             r_q_out,    w_nxt_q_out;
    logic             r_q_valid,  w_nxt_q_valid;
    logic             r_busy,     w_nxt_busy;
    logic [CNT_W-1:0] r_hold_cnt, w_nxt_hold_cnt;

    logic       w_any;
    logic [1:0] w_pick;
    logic       w_others;
    logic       w_hold_end;
    logic       w_d_unused;

    // The data bits reach us only through the external mux (mux_q).
    assign w_d_unused = ^d;

    rr_pick4 u_pick (
        .req  (req),
        .last (r_last),
        .any  (w_any),
        .pick (w_pick)
    );

    // During OWN, sel is the owner index.
    assign w_others   = |(req & ~onehot2(r_sel));
    assign w_hold_end = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_sel      <= '0;
            r_last     <= 2'd3;
            r_q_src    <= '0;
            r_q_out    <= 1'b0;
            r_q_valid  <= 1'b0;
            r_busy     <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_grant    <= w_nxt_grant;
            r_sel      <= w_nxt_sel;
            r_last     <= w_nxt_last;
            r_q_src    <= w_nxt_q_src;
            r_q_out    <= w_nxt_q_out;
            r_q_valid  <= w_nxt_q_valid;
            r_busy     <= w_nxt_busy;
            r_hold_cnt <= w_nxt_hold_cnt;
        end
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_grant    = r_grant;
        w_nxt_sel      = r_sel;
        w_nxt_last     = r_last;
        w_nxt_q_src    = r_q_src;
        w_nxt_q_out    = r_q_out;
        w_nxt_q_valid  = r_q_valid;
        w_nxt_hold_cnt = r_hold_cnt;
        case (r_state)
            IDLE: begin
                w_nxt_q_valid = 1'b0;
                if (w_any) begin
                    w_nxt_state    = OWN;
                    w_nxt_grant    = onehot2(w_pick);
                    w_nxt_sel      = w_pick;
                    w_nxt_hold_cnt = '0;
                end
            end
            OWN: begin
                w_nxt_q_out   = mux_q;
                w_nxt_q_valid = 1'b1;
                w_nxt_q_src   = r_sel;
                if (!req[r_sel] || (w_hold_end && w_others)) begin
                    w_nxt_state = GAP;
                    w_nxt_grant = '0;
                    w_nxt_last  = r_sel;
                end else if (w_hold_end) begin
                    w_nxt_hold_cnt = '0;
                end else begin
                    w_nxt_hold_cnt = r_hold_cnt + CNT_W'(1);
                end
            end
            GAP: begin
                w_nxt_state   = IDLE;
                w_nxt_grant   = '0;
                w_nxt_q_valid = 1'b0;
            end
            default: begin
                w_nxt_state   = IDLE;
                w_nxt_grant   = '0;
                w_nxt_q_valid = 1'b0;
            end
        endcase
        w_nxt_busy = (w_nxt_state != IDLE);
    end

    assign sel     = r_sel;
    assign grant   = r_grant;
    assign q_out   = r_q_out;
    assign q_valid = r_q_valid;
    assign q_src   = r_q_src;
    assign busy    = r_busy;

endmodule
